// File: rtl/vga_pkg.sv
// Shared phase encoding and 640x480@60 timing constants for the VGA raster generator.
package vga_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_XY_W     = 12;

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_ACTIVE: return PH_FP;
            PH_FP:     return PH_SYNC;
            PH_SYNC:   return PH_BP;
            default:   return PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM timed by a down-counter.
//   state     | meaning
//   PH_ACTIVE | visible region
//   PH_FP     | front porch
//   PH_SYNC   | sync pulse
//   PH_BP     | back porch
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int LEN_ACTIVE = VGA_H_ACTIVE,
    parameter int LEN_FP     = VGA_H_FP,
    parameter int LEN_SYNC   = VGA_H_SYNC,
    parameter int LEN_BP     = VGA_H_BP,
    parameter int W          = VGA_XY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         tick,
    output logic [W-1:0] pos,
    output logic [1:0]   phase,
    output logic         wrap
);

    localparam int TOTAL = LEN_ACTIVE + LEN_FP + LEN_SYNC + LEN_BP;

    if (LEN_ACTIVE < 1 || LEN_FP < 1 || LEN_SYNC < 1 || LEN_BP < 1 || TOTAL > 2**W) begin : g_bad_len
        $error("vga_axis_counter: zero phase length or total exceeds counter range");
    end

    phase_t         ph_q, ph_d;
    logic [W-1:0]   pos_q, pos_d;
    logic [W-1:0]   rem_q, rem_d;

    function automatic logic [W-1:0] phase_last(input phase_t p);
        case (p)
            PH_ACTIVE: return W'(LEN_ACTIVE - 1);
            PH_FP:     return W'(LEN_FP - 1);
            PH_SYNC:   return W'(LEN_SYNC - 1);
            default:   return W'(LEN_BP - 1);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ph_q  <= PH_ACTIVE;
            pos_q <= '0;
            rem_q <= W'(LEN_ACTIVE - 1);
        end else begin
            ph_q  <= ph_d;
            pos_q <= pos_d;
            rem_q <= rem_d;
        end
    end

    always_comb begin
        ph_d  = ph_q;
        pos_d = pos_q;
        rem_d = rem_q;
        wrap  = (pos_q == W'(TOTAL - 1));
        if (tick) begin
            pos_d = wrap ? '0 : pos_q + W'(1);
            if (rem_q == '0) begin
                ph_d  = next_phase(ph_q);
                rem_d = phase_last(next_phase(ph_q));
            end else begin
                rem_d = rem_q - W'(1);
            end
        end
    end

    assign pos   = pos_q;
    assign phase = ph_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: stage 0 presents position/request, stage 1 drives the connector pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 1,
    parameter int XY_W     = VGA_XY_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pix_en,
    input  logic [3*CW-1:0] rgb_in,
    output logic [XY_W-1:0] oX,
    output logic [XY_W-1:0] oY,
    output logic            pix_req,
    output logic            sof,
    output logic            eol,
    output logic            oHSync,
    output logic            oVSync,
    output logic            de,
    output logic [3*CW-1:0] colorChannels
);

    logic [XY_W-1:0] hpos, vpos;
    logic [1:0]      hph_raw, vph_raw;
    logic            hwrap, vwrap;
    logic            clr;
    phase_t          hph, vph;
    phase_t          hph_s0, vph_s0;

    assign clr = ~en;
    assign hph = phase_t'(hph_raw);
    assign vph = phase_t'(vph_raw);

    vga_axis_counter #(
        .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .W(XY_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .clr(clr), .tick(pix_en),
        .pos(hpos), .phase(hph_raw), .wrap(hwrap)
    );

    // The line advances on the same tick that presents the last pixel (eol being generated).
    vga_axis_counter #(
        .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .W(XY_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .clr(clr), .tick(pix_en & hwrap),
        .pos(vpos), .phase(vph_raw), .wrap(vwrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            oX      <= '0;
            oY      <= '0;
            pix_req <= 1'b0;
            sof     <= 1'b0;
            eol     <= 1'b0;
            hph_s0  <= PH_ACTIVE;
            vph_s0  <= PH_ACTIVE;
        end else if (pix_en) begin
            oX      <= hpos;
            oY      <= vpos;
            pix_req <= (hph == PH_ACTIVE) && (vph == PH_ACTIVE);
            sof     <= (hpos == '0) && (vpos == '0);
            eol     <= hwrap;
            hph_s0  <= hph;
            vph_s0  <= vph;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            oHSync        <= ~HS_POL;
            oVSync        <= ~VS_POL;
            de            <= 1'b0;
            colorChannels <= '0;
        end else if (pix_en) begin
            oHSync        <= (hph_s0 == PH_SYNC) ? HS_POL : ~HS_POL;
            oVSync        <= (vph_s0 == PH_SYNC) ? VS_POL : ~VS_POL;
            de            <= pix_req;
            colorChannels <= pix_req ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a frame-index reference model (reduced raster).
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 10, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CW = 2;
    localparam int XY_W = 5;

    logic            clk = 1'b0;
    logic            rst_n, en, pix_en;
    logic [3*CW-1:0] rgb_in;

    logic [XY_W-1:0] oX, oY, p_x, p_y;
    logic            pix_req, sof, eol, oHSync, oVSync, de;
    logic            p_req, p_sof, p_eol, p_hs, p_vs, p_de;
    logic [3*CW-1:0] colorChannels, p_col;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit              started;
    int              idx, e_x, e_y;
    logic            e_req, e_sof, e_eol, e_hs, e_vs, e_de;
    logic [3*CW-1:0] e_col;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .XY_W(XY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix_en), .rgb_in(rgb_in),
        .oX(oX), .oY(oY), .pix_req(pix_req), .sof(sof), .eol(eol),
        .oHSync(oHSync), .oVSync(oVSync), .de(de), .colorChannels(colorChannels)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .XY_W(XY_W)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_en(pix_en), .rgb_in(rgb_in),
        .oX(p_x), .oY(p_y), .pix_req(p_req), .sof(p_sof), .eol(p_eol),
        .oHSync(p_hs), .oVSync(p_vs), .de(p_de), .colorChannels(p_col)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Position is the pixel index within the frame; everything else follows from it.
    task automatic model_step();
        if (!rst_n || !en) begin
            started = 1'b0;
            idx   = 0;
            e_x   = 0;
            e_y   = 0;
            e_req = 1'b0;
            e_sof = 1'b0;
            e_eol = 1'b0;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_de  = 1'b0;
            e_col = '0;
        end else if (pix_en) begin
            e_hs  = !(e_x >= HA + HF && e_x < HA + HF + HS);
            e_vs  = !(e_y >= VA + VF && e_y < VA + VF + VS);
            e_de  = e_req;
            e_col = e_req ? rgb_in : '0;
            idx   = started ? (idx + 1) % FT : 0;
            started = 1'b1;
            e_x   = idx % HT;
            e_y   = idx / HT;
            e_req = (e_x < HA) && (e_y < VA);
            e_sof = (idx == 0);
            e_eol = (e_x == HT - 1);
        end
    endtask

    task automatic check_outputs();
        chk("pos",   32'({oX, oY}), 32'({XY_W'(e_x), XY_W'(e_y)}));
        chk("flags", 32'({pix_req, sof, eol}), 32'({e_req, e_sof, e_eol}));
        chk("pins",  32'({oHSync, oVSync, de, colorChannels}), 32'({e_hs, e_vs, e_de, e_col}));
        chk("pol_pins", 32'({p_hs, p_vs, p_de, p_col}), 32'({~e_hs, ~e_vs, e_de, e_col}));
        chk("pol_pos",  32'({p_x, p_y, p_req, p_sof, p_eol}),
            32'({XY_W'(e_x), XY_W'(e_y), e_req, e_sof, e_eol}));
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        pix_en = 1'b1;
        rgb_in = '0;
        model_step();
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            check_outputs();
            rgb_in = (3*CW)'($urandom);
            if (cyc < 5) begin
                rst_n  = 1'b0;
                en     = 1'b1;
                pix_en = 1'b1;
            end else if (cyc < 1300) begin
                rst_n  = 1'b1;
                en     = !(cyc >= 900 && cyc < 903);
                pix_en = 1'b1;
            end else if (cyc < 3700) begin
                rst_n  = 1'b1;
                en     = 1'b1;
                pix_en = (cyc % 4 == 0);
            end else begin
                rst_n  = ($urandom_range(0, 499) != 0);
                en     = ($urandom_range(0, 199) != 0);
                pix_en = $urandom_range(0, 1) == 1;
            end
            model_step();
        end
        @(negedge clk);
        check_outputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
